video_timing_gen: RTL and testbench
===================================

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, active pixels per line; must be a multiple of 8.
REQ-002 SHALL have parameters H_FP 16, H_SYNC 96, H_BP 48: horizontal front porch, sync and back porch widths in pixels.
REQ-003 SHALL have parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33: vertical active lines, front porch, sync and back porch widths in lines.
REQ-004 SHALL have parameter SYNC_POL, default 0, sync polarity: 0 means syncs are active-low, 1 means active-high.
REQ-005 i_pixclk  input  1  pixel clock; the only clock.
REQ-006 i_reset_n  input  1  reset, asynchronous, active-low.
REQ-007 i_en  input  1  run enable for frame generation.
REQ-008 i_pix_data  input  24  upstream pixel data, valid one cycle after o_pix_req; packing {blue[23:16], green[15:8], red[7:0]}.
REQ-009 o_pix_req  output  1  request for the next active pixel.
REQ-010 o_x  output  11  column of the requested pixel; o_y  output  10  row of the requested pixel.
REQ-011 o_rgb_data  output  24  pixel to the TMDS encoder, same packing as i_pix_data.
REQ-012 o_hsync, o_vsync  output  1 each  sync outputs at SYNC_POL polarity; o_de  output  1  data enable.
REQ-013 o_frame_start  output  1  one-cycle pulse aligned with the first active pixel of a frame.

Function
REQ-014 SHALL keep h_cnt in the range 0..H_TOTAL-1 and v_cnt in the range 0..V_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL is the vertical sum.
REQ-015 h_cnt SHALL increment every cycle while running and wrap to 0 at H_TOTAL-1; v_cnt SHALL increment on each h wrap and wrap to 0 at V_TOTAL-1.
REQ-016 Position is active when h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-017 hsync is asserted when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
REQ-018 vsync is asserted for whole lines where V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC.
REQ-019 Stage 1 (registered, 1 cycle after the counters): o_pix_req equals active, and o_x/o_y equal h_cnt/v_cnt when active, otherwise 0.
REQ-020 Stage 2 (registered, 2 cycles after the counters) SHALL produce o_de, o_hsync, o_vsync and o_frame_start.
REQ-021 In stage 2, o_rgb_data SHALL be i_pix_data sampled when the delayed request is high, and 0 otherwise; o_de therefore lags o_pix_req by exactly 1 cycle.
REQ-022 o_frame_start SHALL be high exactly when stage 2 carries h_cnt=0, v_cnt=0.
REQ-023 State machine IDLE/RUN/DRAIN:
  - IDLE: counters held at 0, outputs inactive; on i_en=1, go to RUN, with h_cnt=0, v_cnt=0 counted in the next cycle.
  - RUN: on i_en=0, go to DRAIN.
  - DRAIN: keeps counting; on i_en=1, return to RUN; at the final position (H_TOTAL-1, V_TOTAL-1), wrap and go to IDLE.
REQ-024 A frame SHALL never be truncated by i_en; a deassert/reassert within one frame SHALL cause no discontinuity.
REQ-025 After the last counted position, the pipeline SHALL flush its 2 remaining cycles, then hold outputs inactive.

Reset
REQ-026 Assertion of i_reset_n=0 SHALL immediately force the following, regardless of the clock, including mid-frame:
  - state IDLE and counters 0;
  - o_pix_req, o_de, o_frame_start = 0;
  - o_x, o_y, o_rgb_data = 0;
  - o_hsync and o_vsync at the inactive level (~SYNC_POL).
REQ-027 After reset release, the block SHALL stay in IDLE until i_en is sampled high.

Configuration
REQ-028 When macro COLOR_BAR_EN is defined, o_rgb_data SHALL come from an internal colour-bar pattern and i_pix_data SHALL be ignored; o_pix_req/o_x/o_y behaviour is unchanged.
REQ-029 The colour-bar pattern SHALL use bar = x/(H_ACTIVE/8).
  - Bars 0..7 are white, yellow, cyan, green, magenta, red, blue, black.
  - Colour channels are 8'hFF or 8'h00.
  - Timing is identical to the pass-through case.
REQ-030 When COLOR_BAR_EN is not defined, the pass-through behaviour of REQ-021 applies.

Verification (H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, SYNC_POL=0; H_TOTAL=14, V_TOTAL=7)
REQ-031 Release reset, hold i_en=1 -> o_pix_req high for 8 of every 14 cycles; o_de is the same waveform 1 cycle later; frame period is 98 cycles.
REQ-032 Same run -> o_hsync low for 2 cycles starting 10 cycles after each o_de rise; o_vsync low for 14 cycles per frame, starting at line 5.
REQ-033 Drive i_pix_data = 24'h00_00_00 + o_x + (o_y<<8) one cycle after each request -> o_rgb_data matches sample-for-sample; o_frame_start pulses with pixel (0,0).
REQ-034 Drop i_en in the middle of line 2 -> the frame completes all 98 counts, then outputs go idle; raising i_en again restarts at (0,0) with o_frame_start.
REQ-035 Assert i_reset_n=0 mid-line at an active pixel -> all outputs reach reset values before the next clock edge; o_hsync and o_vsync = 1.
REQ-036 With COLOR_BAR_EN and i_pix_data=24'h123456 -> o_rgb_data is 24'hFFFFFF at x=0, 24'h00FFFF at x=1, 24'hFF0000 at x=6, 24'h000000 at x=7.

Source files
------------

// File: rtl/video_timing_gen.sv
// Raster timing generator with a two-stage output pipeline and an IDLE/RUN/DRAIN frame controller.
// Define COLOR_BAR_EN to replace the upstream pixel stream with an internal eight-bar test pattern.
module video_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int SYNC_POL = 0
) (
   input  logic        i_pixclk,
   input  logic        i_reset_n,
   input  logic        i_en,
   input  logic [23:0] i_pix_data,
   output logic        o_pix_req,
   output logic [10:0] o_x,
   output logic [9:0]  o_y,
   output logic [23:0] o_rgb_data,
   output logic        o_hsync,
   output logic        o_vsync,
   output logic        o_de,
   output logic        o_frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
   localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
   localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
   localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

   localparam logic SYNC_ACT = (SYNC_POL != 0);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t      state;
   logic [10:0] h_cnt;
   logic [9:0]  v_cnt;
   logic        h_last;
   logic        v_last;

   assign h_last = (h_cnt == H_LAST);
   assign v_last = (v_cnt == V_LAST);

   // A frame that has started always runs to its last position; i_en only decides what follows it.
   always_ff @(posedge i_pixclk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state <= IDLE;
         h_cnt <= '0;
         v_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_en) state <= RUN;
            end
            RUN, DRAIN: begin
               if (h_last) begin
                  h_cnt <= '0;
                  v_cnt <= v_last ? '0 : v_cnt + 10'd1;
               end else begin
                  h_cnt <= h_cnt + 11'd1;
               end
               if (h_last && v_last) state <= i_en ? RUN : IDLE;
               else                  state <= i_en ? RUN : DRAIN;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // ---- stage 0: decode of the counted position
   logic vld_p0;
   logic act_p0;
   logic hs_p0;
   logic vs_p0;
   logic fs_p0;

   assign vld_p0 = (state != IDLE);
   assign act_p0 = vld_p0 && (h_cnt < H_ACT) && (v_cnt < V_ACT);
   assign hs_p0  = vld_p0 && (h_cnt >= HS_BEG) && (h_cnt < HS_END);
   assign vs_p0  = vld_p0 && (v_cnt >= VS_BEG) && (v_cnt < VS_END);
   assign fs_p0  = vld_p0 && (h_cnt == 11'd0) && (v_cnt == 10'd0);

   // ---- stage 1: pixel request towards the upstream source
   logic        vld_p1;
   logic [10:0] x_p1;
   logic [9:0]  y_p1;
   logic        hs_p1;
   logic        vs_p1;
   logic        fs_p1;

   always_ff @(posedge i_pixclk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         vld_p1 <= 1'b0;
         x_p1   <= '0;
         y_p1   <= '0;
         hs_p1  <= 1'b0;
         vs_p1  <= 1'b0;
         fs_p1  <= 1'b0;
      end else begin
         vld_p1 <= act_p0;
         x_p1   <= act_p0 ? h_cnt : '0;
         y_p1   <= act_p0 ? v_cnt : '0;
         hs_p1  <= hs_p0;
         vs_p1  <= vs_p0;
         fs_p1  <= fs_p0;
      end
   end

   assign o_pix_req = vld_p1;
   assign o_x       = x_p1;
   assign o_y       = y_p1;

   // ---- stage 2: encoder-facing timing and pixel data
   logic vld_p2;
   logic hs_p2;
   logic vs_p2;
   logic fs_p2;

   always_ff @(posedge i_pixclk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         vld_p2 <= 1'b0;
         hs_p2  <= ~SYNC_ACT;
         vs_p2  <= ~SYNC_ACT;
         fs_p2  <= 1'b0;
      end else begin
         vld_p2 <= vld_p1;
         hs_p2  <= hs_p1 ? SYNC_ACT : ~SYNC_ACT;
         vs_p2  <= vs_p1 ? SYNC_ACT : ~SYNC_ACT;
         fs_p2  <= fs_p1;
      end
   end

   assign o_de          = vld_p2;
   assign o_hsync       = hs_p2;
   assign o_vsync       = vs_p2;
   assign o_frame_start = fs_p2;

`ifdef COLOR_BAR_EN
   localparam logic [10:0] BAR_W = 11'(H_ACTIVE / 8);

   // Packing is {blue, green, red}.
   function automatic logic [23:0] bar_colour(input logic [10:0] x);
      logic [10:0] bar;
      bar = x / BAR_W;
      case (bar[2:0])
         3'd0:    return 24'hFFFFFF;
         3'd1:    return 24'h00FFFF;
         3'd2:    return 24'hFFFF00;
         3'd3:    return 24'h00FF00;
         3'd4:    return 24'hFF00FF;
         3'd5:    return 24'h0000FF;
         3'd6:    return 24'hFF0000;
         default: return 24'h000000;
      endcase
   endfunction

   logic [23:0] rgb_p2;

   always_ff @(posedge i_pixclk or negedge i_reset_n) begin
      if (!i_reset_n) rgb_p2 <= '0;
      else            rgb_p2 <= vld_p1 ? bar_colour(x_p1) : '0;
   end

   assign o_rgb_data = rgb_p2;
`else
   // Upstream answers a request one cycle later, which lines its data up with o_de.
   assign o_rgb_data = vld_p2 ? i_pix_data : '0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a 14x7 raster (8x4 active, active-low syncs).
// Expected outputs come from a closed-form raster model indexed by cycles since enable.
module tb_video_timing_gen;

   localparam int HT  = 14;
   localparam int VT  = 7;
   localparam int FT  = HT * VT;
   localparam int BIG = 1 << 20;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [23:0] pix_in;
   logic        pix_req;
   logic [10:0] x;
   logic [9:0]  y;
   logic [23:0] rgb;
   logic        hsync;
   logic        vsync;
   logic        de;
   logic        fstart;

   int checks   = 0;
   int failures = 0;

   logic [49:0] sb[$];
   logic [49:0] got;
   logic [23:0] pend;

   assign got = {pix_req, x, y, de, hsync, vsync, fstart, rgb};

   video_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .SYNC_POL(0)
   ) dut (
      .i_pixclk      (clk),
      .i_reset_n     (rst_n),
      .i_en          (en),
      .i_pix_data    (pix_in),
      .o_pix_req     (pix_req),
      .o_x           (x),
      .o_y           (y),
      .o_rgb_data    (rgb),
      .o_hsync       (hsync),
      .o_vsync       (vsync),
      .o_de          (de),
      .o_frame_start (fstart)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [23:0] pix_val(int px, int py);
`ifdef COLOR_BAR_EN
      case (px)
         0:       return 24'hFFFFFF;
         1:       return 24'h00FFFF;
         2:       return 24'hFFFF00;
         3:       return 24'h00FF00;
         4:       return 24'hFF00FF;
         5:       return 24'h0000FF;
         6:       return 24'hFF0000;
         default: return 24'h000000;
      endcase
`else
      return 24'(px + (py << 8));
`endif
   endfunction

   // Position n is counted in cycle n after the enabling edge; n_pos positions are counted in total.
   function automatic logic [49:0] exp_out(int t, int n_pos);
      int p1, p2, h, v;
      logic req_e, de_e, hs_e, vs_e, fs_e;
      int xe, ye;
      logic [23:0] rgb_e;
      p1 = t - 1; p2 = t - 2;
      req_e = 0; xe = 0; ye = 0; de_e = 0; hs_e = 1; vs_e = 1; fs_e = 0; rgb_e = '0;
      if (p1 >= 0 && p1 < n_pos) begin
         h = p1 % HT; v = (p1 / HT) % VT;
         if (h < 8 && v < 4) begin req_e = 1; xe = h; ye = v; end
      end
      if (p2 >= 0 && p2 < n_pos) begin
         h = p2 % HT; v = (p2 / HT) % VT;
         de_e = (h < 8 && v < 4);
         hs_e = !(h >= 10 && h < 12);
         vs_e = (v != 5);
         fs_e = (h == 0 && v == 0);
         if (de_e) rgb_e = pix_val(h, v);
      end
      return {req_e, 11'(xe), 10'(ye), de_e, hs_e, vs_e, fs_e, rgb_e};
   endfunction

   function automatic logic [49:0] reset_vec();
      return {1'b0, 11'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 24'd0};
   endfunction

   // Upstream source: answers each request with its pixel one cycle later, junk otherwise.
   initial begin
      pix_in = '0;
      pend   = '0;
      forever begin
         @(posedge clk);
         #1;
`ifdef COLOR_BAR_EN
         pix_in = 24'h123456;
`else
         pix_in = pend;
         pend   = pix_req ? 24'(x) + (24'(y) << 8) : 24'($urandom);
`endif
      end
   end

   task automatic apply_reset();
      en = 1'b0;
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic start_en();
      @(negedge clk) en = 1'b1;
      @(posedge clk);
   endtask

   task automatic test_reset();
      logic [49:0] e;
      en = 1'b0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (got !== reset_vec()) begin
         failures++;
         $display("FAIL reset_async got=%h exp=%h", got, reset_vec());
      end
      @(negedge clk) rst_n = 1'b1;
      for (int t = 0; t < 8; t++) begin
         @(posedge clk);
         sb.push_back(exp_out(t, 0));
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (got !== e) begin
            failures++;
            $display("FAIL idle_after_reset t=%0d got=%h exp=%h", t, got, e);
         end
      end
   endtask

   task automatic test_frame();
      logic [49:0] e;
      apply_reset();
      start_en();
      for (int t = 0; t < 2 * FT + 4; t++) begin
         sb.push_back(exp_out(t, BIG));
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (got !== e) begin
            failures++;
            $display("FAIL frame t=%0d got=%h exp=%h", t, got, e);
         end
         @(posedge clk);
      end
   endtask

   task automatic test_drain();
      logic [49:0] e;
      apply_reset();
      start_en();
      for (int t = 0; t < FT + 8; t++) begin
         sb.push_back(exp_out(t, FT));
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (got !== e) begin
            failures++;
            $display("FAIL drain t=%0d got=%h exp=%h", t, got, e);
         end
         if (t == 2 * HT + 4) en = 1'b0;
         @(posedge clk);
      end
      start_en();
      for (int t = 0; t < 20; t++) begin
         sb.push_back(exp_out(t, BIG));
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (got !== e) begin
            failures++;
            $display("FAIL restart t=%0d got=%h exp=%h", t, got, e);
         end
         @(posedge clk);
      end
   endtask

   task automatic test_back_to_back();
      logic [49:0] e;
      apply_reset();
      start_en();
      for (int t = 0; t < 2 * FT + 4; t++) begin
         sb.push_back(exp_out(t, BIG));
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (got !== e) begin
            failures++;
            $display("FAIL en_toggle t=%0d got=%h exp=%h", t, got, e);
         end
         if (t == 40 || t == 150) en = 1'b0;
         if (t == 45 || t == 152) en = 1'b1;
         @(posedge clk);
      end
   endtask

   task automatic test_reset_mid();
      logic [49:0] e;
      apply_reset();
      start_en();
      for (int t = 0; t < 7; t++) begin
         sb.push_back(exp_out(t, BIG));
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (got !== e) begin
            failures++;
            $display("FAIL pre_reset t=%0d got=%h exp=%h", t, got, e);
         end
         if (t < 6) @(posedge clk);
      end
      #2 rst_n = 1'b0;
      en = 1'b0;
      #1;
      checks++;
      if (got !== reset_vec()) begin
         failures++;
         $display("FAIL reset_mid_line got=%h exp=%h", got, reset_vec());
      end
      @(negedge clk) rst_n = 1'b1;
      for (int t = 0; t < 4; t++) begin
         @(posedge clk);
         sb.push_back(exp_out(t, 0));
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (got !== e) begin
            failures++;
            $display("FAIL hold_idle t=%0d got=%h exp=%h", t, got, e);
         end
      end
      start_en();
      for (int t = 0; t < 8; t++) begin
         sb.push_back(exp_out(t, BIG));
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (got !== e) begin
            failures++;
            $display("FAIL post_reset t=%0d got=%h exp=%h", t, got, e);
         end
         @(posedge clk);
      end
   endtask

   initial begin
      rst_n = 1'b1;
      en    = 1'b0;
      test_reset();
      test_frame();
      test_drain();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
